// File: rtl/register_file.sv
// Parametrised register file with N registered read ports, one write port and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and post-update busy to matching reads.
module register_file #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG     = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_RD_PORTS*AW-1:0]   Rd_addr,
  input  logic [NUM_RD_PORTS-1:0]      Rd_valid,
  output logic [NUM_RD_PORTS*XLEN-1:0] Rd_data,
  output logic [NUM_RD_PORTS-1:0]      Rd_busy,
  input  logic [AW-1:0]                Wr_addr,
  input  logic                         Wr_valid,
  input  logic [XLEN-1:0]              Wr_data,
  input  logic [AW-1:0]                Claim_addr,
  input  logic                         Claim_valid,
  output logic                         Claim_err,
  output logic [NUM_REGS-1:0]          Busy_vec
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                claim_err_q;
  logic                claim_err_d;
  logic                wr_en;
  logic                claim_en;

  // With a hardwired zero register, address 0 never takes data or a claim, so it stays 0 / not busy.
  assign wr_en    = Wr_valid    && !((ZERO_REG != 0) && (Wr_addr == '0));
  assign claim_en = Claim_valid && !((ZERO_REG != 0) && (Claim_addr == '0));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[Wr_addr] = Wr_data;
      busy_d[Wr_addr] = 1'b0;
    end
    // Claim is applied after the write so a same-address claim leaves the register busy.
    if (claim_en) begin
      busy_d[Claim_addr] = 1'b1;
    end
    claim_err_d = claim_en && busy_q[Claim_addr] && !(wr_en && (Wr_addr == Claim_addr));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  assign Claim_err = claim_err_q;
  assign Busy_vec  = busy_q;

  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    logic            busy_rd_q;
    logic            busy_rd_d;

    assign addr = Rd_addr[gi*AW +: AW];

    always_comb begin
      data_d    = data_q;
      busy_rd_d = busy_rd_q;
      if (Rd_valid[gi]) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (Wr_addr == addr)) begin
          data_d    = Wr_data;
          busy_rd_d = busy_d[addr];
        end else begin
          data_d    = regs_q[addr];
          busy_rd_d = busy_q[addr];
        end
`else
        data_d    = regs_q[addr];
        busy_rd_d = busy_q[addr];
`endif
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        data_q    <= '0;
        busy_rd_q <= 1'b0;
      end else begin
        data_q    <= data_d;
        busy_rd_q <= busy_rd_d;
      end
    end

    assign Rd_data[gi*XLEN +: XLEN] = data_q;
    assign Rd_busy[gi]              = busy_rd_q;
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a default 2-port/32-bit instance and a 4-port/64-bit instance.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  logic [9:0]   a_rd_addr;
  logic [1:0]   a_rd_valid;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic [4:0]   a_wr_addr;
  logic         a_wr_valid;
  logic [31:0]  a_wr_data;
  logic [4:0]   a_claim_addr;
  logic         a_claim_valid;
  logic         a_claim_err;
  logic [31:0]  a_busy_vec;

  logic [19:0]  b_rd_addr;
  logic [3:0]   b_rd_valid;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [4:0]   b_wr_addr;
  logic         b_wr_valid;
  logic [63:0]  b_wr_data;
  logic [4:0]   b_claim_addr;
  logic         b_claim_valid;
  logic         b_claim_err;
  logic [31:0]  b_busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  register_file dut_a (
    .Clk(clk), .Rst(rst),
    .Rd_addr(a_rd_addr), .Rd_valid(a_rd_valid), .Rd_data(a_rd_data), .Rd_busy(a_rd_busy),
    .Wr_addr(a_wr_addr), .Wr_valid(a_wr_valid), .Wr_data(a_wr_data),
    .Claim_addr(a_claim_addr), .Claim_valid(a_claim_valid), .Claim_err(a_claim_err),
    .Busy_vec(a_busy_vec)
  );

  register_file #(.XLEN(64), .NUM_REGS(32), .NUM_RD_PORTS(4), .ZERO_REG(1)) dut_b (
    .Clk(clk), .Rst(rst),
    .Rd_addr(b_rd_addr), .Rd_valid(b_rd_valid), .Rd_data(b_rd_data), .Rd_busy(b_rd_busy),
    .Wr_addr(b_wr_addr), .Wr_valid(b_wr_valid), .Wr_data(b_wr_data),
    .Claim_addr(b_claim_addr), .Claim_valid(b_claim_valid), .Claim_err(b_claim_err),
    .Busy_vec(b_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_rd_valid = '0; a_wr_valid = 1'b0; a_claim_valid = 1'b0;
    b_rd_valid = '0; b_wr_valid = 1'b0; b_claim_valid = 1'b0;
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
    a_wr_addr = addr; a_wr_data = data; a_wr_valid = 1'b1;
    step();
    a_wr_valid = 1'b0;
  endtask

  task automatic b_write(input logic [4:0] addr, input logic [63:0] data);
    b_wr_addr = addr; b_wr_data = data; b_wr_valid = 1'b1;
    step();
    b_wr_valid = 1'b0;
  endtask

  initial begin
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_claim_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_claim_addr = '0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_busy_vec", 64'(a_busy_vec), 64'h0);
    check("rst_claim_err", 64'(a_claim_err), 64'h0);
    check("rst_rd_data", a_rd_data, 64'h0);
    check("rst_b_rd_data_p3", b_rd_data[3*64 +: 64], 64'h0);

    for (int i = 0; i < 32; i++) begin
      a_rd_addr  = {5'(i), 5'(i)};
      a_rd_valid = 2'b11;
      step();
      check($sformatf("rst_rd_%0d", i), {a_rd_data[63:32], a_rd_data[31:0]}, 64'h0);
      check($sformatf("rst_busy_%0d", i), 64'(a_rd_busy), 64'h0);
    end
    idle();

    // Write reg5 then read reg5 on port 0 and reg0 on port 1
    a_write(5'd5, 32'hDEAD_BEEF);
    a_rd_addr = {5'd0, 5'd5}; a_rd_valid = 2'b11;
    step();
    check("rd5_p0", 64'(a_rd_data[31:0]), 64'hDEAD_BEEF);
    check("rd0_p1", 64'(a_rd_data[63:32]), 64'h0);
    // Ports hold when not enabled
    a_rd_addr = {5'd9, 5'd9}; a_rd_valid = 2'b00;
    step();
    check("hold_p0", 64'(a_rd_data[31:0]), 64'hDEAD_BEEF);
    a_write(5'd0, 32'h1234);
    a_rd_addr = {5'd0, 5'd0}; a_rd_valid = 2'b01;
    step();
    check("rd0_after_wr", 64'(a_rd_data[31:0]), 64'h0);
    idle();

    // Double claim of reg7
    a_claim_addr = 5'd7; a_claim_valid = 1'b1;
    step();
    check("claim7_busy", 64'(a_busy_vec[7]), 64'h1);
    check("claim7_err_first", 64'(a_claim_err), 64'h0);
    a_rd_addr = {5'd7, 5'd0}; a_rd_valid = 2'b10;
    step();
    check("claim7_err_second", 64'(a_claim_err), 64'h1);
    check("rd7_busy_p1", 64'(a_rd_busy[1]), 64'h1);
    idle();
    step();
    check("claim7_err_pulse_end", 64'(a_claim_err), 64'h0);
    check("claim7_still_busy", 64'(a_busy_vec[7]), 64'h1);
    a_write(5'd7, 32'h55);
    check("wr7_clears_busy", 64'(a_busy_vec[7]), 64'h0);
    a_rd_addr = {5'd0, 5'd7}; a_rd_valid = 2'b01;
    step();
    check("rd7_data", 64'(a_rd_data[31:0]), 64'h55);
    check("rd7_busy", 64'(a_rd_busy[0]), 64'h0);
    idle();

    // Same-cycle write and read of reg9
    a_write(5'd9, 32'h11);
    a_wr_addr = 5'd9; a_wr_data = 32'hA5A5_A5A5; a_wr_valid = 1'b1;
    a_rd_addr = {5'd0, 5'd9}; a_rd_valid = 2'b01;
    step();
    a_wr_valid = 1'b0;
    check("raw9_same_cycle", 64'(a_rd_data[31:0]), BYP ? 64'hA5A5_A5A5 : 64'h11);
    step();
    check("raw9_followup", 64'(a_rd_data[31:0]), 64'hA5A5_A5A5);
    idle();

    // Claim + write of busy reg3 in one cycle
    a_claim_addr = 5'd3; a_claim_valid = 1'b1;
    step();
    a_wr_addr = 5'd3; a_wr_data = 32'hCAFE; a_wr_valid = 1'b1;
    step();
    idle();
    check("cw3_busy", 64'(a_busy_vec[3]), 64'h1);
    check("cw3_no_err", 64'(a_claim_err), 64'h0);
    a_rd_addr = {5'd0, 5'd3}; a_rd_valid = 2'b01;
    step();
    check("cw3_data", 64'(a_rd_data[31:0]), 64'hCAFE);
    check("cw3_rd_busy", 64'(a_rd_busy[0]), 64'h1);
    idle();

    // Claims of reg0 are ignored
    a_claim_addr = 5'd0; a_claim_valid = 1'b1;
    step();
    step();
    check("claim0_no_err", 64'(a_claim_err), 64'h0);
    check("claim0_not_busy", 64'(a_busy_vec[0]), 64'h0);
    idle();

    // Reset mid-operation with reg12 claimed and written
    a_claim_addr = 5'd12; a_claim_valid = 1'b1;
    step();
    a_wr_addr = 5'd12; a_wr_data = 32'h77; a_wr_valid = 1'b1;
    step();
    check("cw12_no_err", 64'(a_claim_err), 64'h0);
    a_wr_data = 32'h99; a_claim_addr = 5'd13;
    a_rd_addr = {5'd12, 5'd12}; a_rd_valid = 2'b11;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("mid_rst_busy_vec", 64'(a_busy_vec), 64'h0);
    check("mid_rst_claim_err", 64'(a_claim_err), 64'h0);
    check("mid_rst_rd_data", a_rd_data, 64'h0);
    a_rd_addr = {5'd5, 5'd12}; a_rd_valid = 2'b11;
    step();
    check("post_rst_rd12", 64'(a_rd_data[31:0]), 64'h0);
    check("post_rst_rd5", 64'(a_rd_data[63:32]), 64'h0);
    idle();

    // Wide 4-port instance
    b_write(5'd1, 64'h0123_4567_89AB_CDEF);
    b_write(5'd31, 64'hFEDC_BA98_7654_3210);
    b_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    b_rd_addr = {5'd0, 5'd1, 5'd31, 5'd1}; b_rd_valid = 4'b1111;
    step();
    check("b_p0_rd1", b_rd_data[0 +: 64], 64'h0123_4567_89AB_CDEF);
    check("b_p1_rd31", b_rd_data[64 +: 64], 64'hFEDC_BA98_7654_3210);
    check("b_p2_rd1", b_rd_data[128 +: 64], 64'h0123_4567_89AB_CDEF);
    check("b_p3_rd0", b_rd_data[192 +: 64], 64'h0);
    b_rd_addr = {5'd0, 5'd31, 5'd0, 5'd0}; b_rd_valid = 4'b0100;
    step();
    check("b_p2_rd31", b_rd_data[128 +: 64], 64'hFEDC_BA98_7654_3210);
    check("b_p0_hold", b_rd_data[0 +: 64], 64'h0123_4567_89AB_CDEF);
    // Same-cycle write + claim + read of reg1 on port 3
    b_wr_addr = 5'd1; b_wr_data = 64'hAAAA_5555_AAAA_5555; b_wr_valid = 1'b1;
    b_claim_addr = 5'd1; b_claim_valid = 1'b1;
    b_rd_addr = {5'd1, 5'd0, 5'd0, 5'd0}; b_rd_valid = 4'b1000;
    step();
    b_wr_valid = 1'b0; b_claim_valid = 1'b0;
    check("b_raw1_data", b_rd_data[192 +: 64], BYP ? 64'hAAAA_5555_AAAA_5555 : 64'h0123_4567_89AB_CDEF);
    check("b_raw1_busy", 64'(b_rd_busy[3]), BYP ? 64'h1 : 64'h0);
    check("b_raw1_no_err", 64'(b_claim_err), 64'h0);
    step();
    check("b_rd1_followup", b_rd_data[192 +: 64], 64'hAAAA_5555_AAAA_5555);
    check("b_rd1_followup_busy", 64'(b_rd_busy[3]), 64'h1);
    check("b_busy_vec", 64'(b_busy_vec), 64'h2);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
